// File: rtl/uart_pkg.sv
// Shared definitions for the UART command parser: command byte layout,
// ACK/NAK codes, and the parser and transmit-feeder state encodings.
package uart_pkg;

   localparam int RD_BIT   = 7;
   localparam int ADDR_MSB = 6;

   localparam logic [7:0] ACK = 8'h06;
   localparam logic [7:0] NAK = 8'h15;

   typedef enum logic [2:0] {
      S_IDLE,
      S_DATA,
      S_CHK,
      S_COMMIT,
      S_RD_LOAD,
      S_TX
   } parser_state_t;

   typedef enum logic [1:0] {
      F_IDLE,
      F_REQ,
      F_DONE
   } feed_state_t;

endpackage

// File: rtl/uart_tx_feeder.sv
// Sends a multi-byte word LSB first through the UART transmit handshake,
// one byte per request/busy cycle; start launches, done pulses at the end.
module uart_tx_feeder
   import uart_pkg::*;
#(
   parameter int W = 40
) (
   input  logic         clk,
   input  logic         rst,
   input  logic         start,
   input  logic [W-1:0] data,
   input  logic [7:0]   nbytes,
   input  logic         tx_busy,
   output logic         tx_transmit,
   output logic [7:0]   tx_byte,
   output logic         done
);

   feed_state_t  state;
   logic [W-1:0] shift;
   logic [7:0]   cnt;
   logic [7:0]   nb;

   always_ff @(posedge clk) begin
      if (rst) begin
         state       <= F_IDLE;
         shift       <= '0;
         cnt         <= '0;
         nb          <= '0;
         tx_transmit <= 1'b0;
         tx_byte     <= '0;
         done        <= 1'b0;
      end else begin
         done <= 1'b0;
         case (state)
            F_IDLE: begin
               if (start && nbytes != 8'd0) begin
                  shift       <= data;
                  nb          <= nbytes;
                  cnt         <= '0;
                  tx_byte     <= data[7:0];
                  tx_transmit <= 1'b1;
                  state       <= F_REQ;
               end
            end
            // Request drops as soon as busy is seen so the transmitter's
            // recover state releases after exactly one byte.
            F_REQ: begin
               if (tx_busy) begin
                  tx_transmit <= 1'b0;
                  state       <= F_DONE;
               end
            end
            F_DONE: begin
               if (!tx_busy) begin
                  shift <= shift >> 8;
                  cnt   <= cnt + 8'd1;
                  if ((cnt + 8'd1) < nb) begin
                     tx_byte     <= shift[15:8];
                     tx_transmit <= 1'b1;
                     state       <= F_REQ;
                  end else begin
                     done  <= 1'b1;
                     state <= F_IDLE;
                  end
               end
            end
            default: state <= F_IDLE;
         endcase
      end
   end

endmodule

// File: rtl/uart_cmd_parser.sv
// Decodes UART command frames into register-bank writes and read replies.
// Optional trailing XOR checksum with ACK/NAK when UART_CMD_CHECKSUM_EN is defined.
module uart_cmd_parser
   import uart_pkg::*;
#(
   parameter int NREG           = 16,
   parameter int REG_W          = 32,
   parameter int TIMEOUT_CYCLES = 12000
) (
   input  logic                  clk,
   input  logic                  rst,
   input  logic                  rx_received,
   input  logic [7:0]            rx_byte,
   input  logic                  rx_error,
   output logic                  tx_transmit,
   output logic [7:0]            tx_byte,
   input  logic                  tx_busy,
   output logic [NREG*REG_W-1:0] regs_flat,
   output logic                  wr_strobe,
   output logic [6:0]            wr_addr,
   output logic                  frame_err
);

   localparam int NB = REG_W / 8;
   localparam int TW = $clog2(TIMEOUT_CYCLES + 1);
   localparam int FW = REG_W + 8;
   localparam int AW = (NREG > 1) ? $clog2(NREG) : 1;

`ifdef UART_CMD_CHECKSUM_EN
   localparam parser_state_t AFTER_DATA = S_CHK;
`else
   localparam parser_state_t AFTER_DATA = S_COMMIT;
`endif

   parser_state_t    state;
   logic [6:0]       addr;
   logic [REG_W-1:0] asm_data;
   logic [7:0]       cnt;
   logic [TW-1:0]    timer;
   logic [REG_W-1:0] regs [NREG];

   logic             feed_start;
   logic [FW-1:0]    feed_data;
   logic [7:0]       feed_nb;
   logic             feed_done;

   logic             addr_ok;
   logic             timed_out;
   logic [REG_W-1:0] rd_val;

`ifdef UART_CMD_CHECKSUM_EN
   logic             is_rd;
   logic [7:0]       csum;
   logic [7:0]       rd_xor;

   always_comb begin
      rd_xor = '0;
      for (int unsigned i = 0; i < NB; i++) rd_xor = rd_xor ^ rd_val[i*8 +: 8];
   end
`endif

   assign addr_ok   = int'(addr) < NREG;
   assign timed_out = (timer == TW'(TIMEOUT_CYCLES - 1));
   assign rd_val    = addr_ok ? regs[addr[AW-1:0]] : '0;

   always_comb begin
      regs_flat = '0;
      for (int unsigned i = 0; i < NREG; i++) regs_flat[i*REG_W +: REG_W] = regs[i];
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state      <= S_IDLE;
         addr       <= '0;
         asm_data   <= '0;
         cnt        <= '0;
         timer      <= '0;
         wr_strobe  <= 1'b0;
         wr_addr    <= '0;
         frame_err  <= 1'b0;
         feed_start <= 1'b0;
         feed_data  <= '0;
         feed_nb    <= '0;
         for (int unsigned i = 0; i < NREG; i++) regs[i] <= '0;
`ifdef UART_CMD_CHECKSUM_EN
         is_rd      <= 1'b0;
         csum       <= '0;
`endif
      end else begin
         wr_strobe  <= 1'b0;
         frame_err  <= 1'b0;
         feed_start <= 1'b0;
         case (state)
            S_IDLE: begin
               if (rx_error) begin
                  frame_err <= 1'b1;
               end else if (rx_received) begin
                  addr  <= rx_byte[ADDR_MSB:0];
                  cnt   <= '0;
                  timer <= '0;
`ifdef UART_CMD_CHECKSUM_EN
                  is_rd <= rx_byte[RD_BIT];
                  csum  <= rx_byte;
                  state <= rx_byte[RD_BIT] ? S_CHK : S_DATA;
`else
                  state <= rx_byte[RD_BIT] ? S_RD_LOAD : S_DATA;
`endif
               end
            end
            // Bytes shift in from the top so the first byte lands at the LSB.
            S_DATA: begin
               if (rx_error) begin
                  frame_err <= 1'b1;
                  state     <= S_IDLE;
               end else if (rx_received) begin
                  timer    <= '0;
                  asm_data <= (asm_data >> 8) | (REG_W'(rx_byte) << (REG_W - 8));
                  cnt      <= cnt + 8'd1;
`ifdef UART_CMD_CHECKSUM_EN
                  csum     <= csum ^ rx_byte;
`endif
                  if (cnt == 8'(NB - 1)) state <= AFTER_DATA;
               end else if (timed_out) begin
                  frame_err <= 1'b1;
                  state     <= S_IDLE;
               end else begin
                  timer <= timer + TW'(1);
               end
            end
`ifdef UART_CMD_CHECKSUM_EN
            S_CHK: begin
               if (rx_error) begin
                  frame_err <= 1'b1;
                  state     <= S_IDLE;
               end else if (rx_received) begin
                  timer <= '0;
                  if (rx_byte == csum) begin
                     state <= is_rd ? S_RD_LOAD : S_COMMIT;
                  end else begin
                     frame_err  <= 1'b1;
                     feed_start <= 1'b1;
                     feed_data  <= FW'(NAK);
                     feed_nb    <= 8'd1;
                     state      <= S_TX;
                  end
               end else if (timed_out) begin
                  frame_err <= 1'b1;
                  state     <= S_IDLE;
               end else begin
                  timer <= timer + TW'(1);
               end
            end
`endif
            S_COMMIT: begin
               if (addr_ok) begin
                  regs[addr[AW-1:0]] <= asm_data;
                  wr_strobe          <= 1'b1;
                  wr_addr            <= addr;
               end else begin
                  frame_err <= 1'b1;
               end
`ifdef UART_CMD_CHECKSUM_EN
               // An out-of-range write with a good checksum is still refused.
               feed_start <= 1'b1;
               feed_data  <= FW'(addr_ok ? ACK : NAK);
               feed_nb    <= 8'd1;
               state      <= S_TX;
`else
               state <= S_IDLE;
`endif
            end
            S_RD_LOAD: begin
               frame_err  <= !addr_ok || rx_received;
               feed_start <= 1'b1;
`ifdef UART_CMD_CHECKSUM_EN
               feed_data  <= {rd_xor, rd_val};
               feed_nb    <= 8'(NB + 1);
`else
               feed_data  <= FW'(rd_val);
               feed_nb    <= 8'(NB);
`endif
               state      <= S_TX;
            end
            S_TX: begin
               if (rx_received) frame_err <= 1'b1;
               if (feed_done) state <= S_IDLE;
            end
            default: state <= S_IDLE;
         endcase
      end
   end

   uart_tx_feeder #(
      .W (FW)
   ) u_feeder (
      .clk         (clk),
      .rst         (rst),
      .start       (feed_start),
      .data        (feed_data),
      .nbytes      (feed_nb),
      .tx_busy     (tx_busy),
      .tx_transmit (tx_transmit),
      .tx_byte     (tx_byte),
      .done        (feed_done)
   );

endmodule

// File: tb/tb_uart_cmd_parser.sv
// Directed bench for uart_cmd_parser with a behavioural UART transmitter;
// checksum scenarios are selected by UART_CMD_CHECKSUM_EN.
module tb_uart_cmd_parser;

   localparam int NREG     = 16;
   localparam int REG_W    = 32;
   localparam int T        = 12000;
   localparam int BUSY_LEN = 8;

   logic                  clk = 1'b0;
   logic                  rst;
   logic                  rx_received;
   logic [7:0]            rx_byte;
   logic                  rx_error;
   logic                  tx_transmit;
   logic [7:0]            tx_byte;
   logic                  tx_busy;
   logic [NREG*REG_W-1:0] regs_flat;
   logic                  wr_strobe;
   logic [6:0]            wr_addr;
   logic                  frame_err;

   int n_checks = 0;
   int n_fail   = 0;
   int wr_cnt   = 0;
   int err_cnt  = 0;
   int viol     = 0;
   int mstate   = 0;
   int busy_left;
   int age;
   logic [7:0] txq[$];

   uart_cmd_parser #(
      .NREG           (NREG),
      .REG_W          (REG_W),
      .TIMEOUT_CYCLES (T)
   ) dut (
      .clk         (clk),
      .rst         (rst),
      .rx_received (rx_received),
      .rx_byte     (rx_byte),
      .rx_error    (rx_error),
      .tx_transmit (tx_transmit),
      .tx_byte     (tx_byte),
      .tx_busy     (tx_busy),
      .regs_flat   (regs_flat),
      .wr_strobe   (wr_strobe),
      .wr_addr     (wr_addr),
      .frame_err   (frame_err)
   );

   always #5 clk = ~clk;

   // Transmitter model: idle -> busy for BUSY_LEN cycles -> recover until request drops.
   always @(posedge clk) begin
      if (rst) begin
         mstate  <= 0;
         tx_busy <= 1'b0;
      end else begin
         case (mstate)
            0: if (tx_transmit) begin
               txq.push_back(tx_byte);
               tx_busy   <= 1'b1;
               busy_left <= BUSY_LEN;
               age       <= 0;
               mstate    <= 1;
            end
            1: begin
               age <= age + 1;
               if (age >= 1 && tx_transmit) viol <= viol + 1;
               if (busy_left == 1) begin
                  tx_busy <= 1'b0;
                  mstate  <= 2;
               end else begin
                  busy_left <= busy_left - 1;
               end
            end
            default: if (!tx_transmit) mstate <= 0;
         endcase
      end
   end

   always @(negedge clk) begin
      if (wr_strobe) wr_cnt++;
      if (frame_err) err_cnt++;
   end

   initial begin
      #2ms;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h expected %0h", name, act, exp);
      end
   endtask

   task automatic idle(input int n);
      repeat (n) @(negedge clk);
   endtask

   task automatic send_byte(input logic [7:0] b);
      rx_byte     = b;
      rx_received = 1'b1;
      @(negedge clk);
      rx_received = 1'b0;
   endtask

   task automatic pulse_err(input logic with_byte, input logic [7:0] b);
      rx_byte     = b;
      rx_error    = 1'b1;
      rx_received = with_byte;
      @(negedge clk);
      rx_error    = 1'b0;
      rx_received = 1'b0;
   endtask

   task automatic wait_tx(input int target);
      for (int i = 0; i < 2000; i++) begin
         @(negedge clk);
         if (txq.size() >= target && mstate == 0 && !tx_transmit) break;
      end
      idle(3);
   endtask

   task automatic write_frame(input logic [6:0] a, input logic [31:0] d, input int gap);
      send_byte({1'b0, a});
      for (int i = 0; i < 4; i++) begin
         idle(gap);
         send_byte(d[i*8 +: 8]);
      end
   endtask

   task automatic read_frame(input logic [6:0] a, output logic [31:0] got, output int nbytes);
      int base;
      base = txq.size();
      send_byte({1'b1, a});
      wait_tx(base + 4);
      nbytes = txq.size() - base;
      got = '0;
      for (int i = 0; i < nbytes && i < 4; i++) got[i*8 +: 8] = txq[base + i];
   endtask

   function automatic logic [31:0] reg_at(input int a);
      return regs_flat[a*REG_W +: REG_W];
   endfunction

   typedef struct {
      logic [6:0]  addr;
      logic [31:0] wdata;
      logic        valid;
   } vec_t;

   vec_t vecs[7];

   initial begin
      int e0, w0, q0, nb;
      logic [31:0] got;

      vecs[0] = '{7'd3,  32'h12345678, 1'b1};
      vecs[1] = '{7'd0,  32'hDEADBEEF, 1'b1};
      vecs[2] = '{7'd15, 32'hA5A50FF0, 1'b1};
      vecs[3] = '{7'h20, 32'hCAFEF00D, 1'b0};
      vecs[4] = '{7'd16, 32'h00000001, 1'b0};
      vecs[5] = '{7'h7F, 32'hFFFFFFFF, 1'b0};
      vecs[6] = '{7'd9,  32'h00FF00FF, 1'b1};

      rst = 1'b1; rx_received = 1'b0; rx_byte = '0; rx_error = 1'b0;
      repeat (3) @(negedge clk);
      check("rst_regs",     64'(regs_flat == '0), 64'd1);
      check("rst_tx_tx",    64'(tx_transmit), 64'd0);
      check("rst_tx_byte",  64'(tx_byte), 64'd0);
      check("rst_wr_strb",  64'(wr_strobe), 64'd0);
      check("rst_wr_addr",  64'(wr_addr), 64'd0);
      check("rst_ferr",     64'(frame_err), 64'd0);
      rst = 1'b0;
      idle(2);

`ifndef UART_CMD_CHECKSUM_EN
      foreach (vecs[v]) begin
         e0 = err_cnt; w0 = wr_cnt; q0 = txq.size();
         write_frame(vecs[v].addr, vecs[v].wdata, 2);
         idle(4);
         check($sformatf("v%0d_wr_cnt", v),  64'(wr_cnt - w0), 64'(vecs[v].valid));
         check($sformatf("v%0d_wr_err", v),  64'(err_cnt - e0), 64'(!vecs[v].valid));
         check($sformatf("v%0d_no_tx", v),   64'(txq.size() - q0), 64'd0);
         if (vecs[v].valid) begin
            check($sformatf("v%0d_wr_addr", v), 64'(wr_addr), 64'(vecs[v].addr));
            check($sformatf("v%0d_reg", v),     64'(reg_at(int'(vecs[v].addr))), 64'(vecs[v].wdata));
         end
         e0 = err_cnt;
         read_frame(vecs[v].addr, got, nb);
         check($sformatf("v%0d_rd_nbytes", v), 64'(nb), 64'd4);
         check($sformatf("v%0d_rd_data", v),   64'(got), vecs[v].valid ? 64'(vecs[v].wdata) : 64'd0);
         check($sformatf("v%0d_rd_err", v),    64'(err_cnt - e0), 64'(!vecs[v].valid));
         check($sformatf("v%0d_tx_hold", v),   64'(viol), 64'd0);
      end

      // Inter-byte timeout aborts a partial write.
      e0 = err_cnt; w0 = wr_cnt;
      send_byte(8'h05); idle(2); send_byte(8'h11); idle(2); send_byte(8'h22);
      idle(T + 1);
      check("tmo_err",   64'(err_cnt - e0), 64'd1);
      check("tmo_no_wr", 64'(wr_cnt - w0), 64'd0);
      check("tmo_reg5",  64'(reg_at(5)), 64'd0);

      // Commit lands exactly one cycle after the last data strobe.
      send_byte(8'h05); idle(2); send_byte(8'hAA); idle(2); send_byte(8'hBB);
      idle(2); send_byte(8'hCC); idle(2); send_byte(8'hDD);
      check("commit_pre_reg",  64'(reg_at(5)), 64'd0);
      check("commit_pre_strb", 64'(wr_strobe), 64'd0);
      @(negedge clk);
      check("commit_reg5",  64'(reg_at(5)), 64'hDDCCBBAA);
      check("commit_strb",  64'(wr_strobe), 64'd1);
      check("commit_waddr", 64'(wr_addr), 64'd5);
      @(negedge clk);
      check("commit_strb_1cyc", 64'(wr_strobe), 64'd0);

      // A gap of T-1 idle cycles is still inside the frame.
      e0 = err_cnt;
      send_byte(8'h06); idle(T - 1); send_byte(8'h04);
      idle(2); send_byte(8'h03); idle(2); send_byte(8'h02); idle(2); send_byte(8'h01);
      idle(3);
      check("gap_edge_err",  64'(err_cnt - e0), 64'd0);
      check("gap_edge_reg6", 64'(reg_at(6)), 64'h01020304);

      // rx_error mid-frame, then a clean frame.
      e0 = err_cnt; w0 = wr_cnt;
      send_byte(8'h01); idle(2); send_byte(8'h11); idle(2);
      pulse_err(1'b0, 8'h00); idle(3);
      check("rxerr_err",   64'(err_cnt - e0), 64'd1);
      check("rxerr_no_wr", 64'(wr_cnt - w0), 64'd0);
      write_frame(7'd1, 32'h44332211, 2); idle(3);
      check("rxerr_reg1",  64'(reg_at(1)), 64'h44332211);

      // rx_error and rx_received together: error wins.
      e0 = err_cnt; w0 = wr_cnt;
      send_byte(8'h01); idle(2); send_byte(8'h99); idle(2);
      pulse_err(1'b1, 8'h88); idle(3);
      check("both_err",   64'(err_cnt - e0), 64'd1);
      check("both_no_wr", 64'(wr_cnt - w0), 64'd0);
      check("both_reg1",  64'(reg_at(1)), 64'h44332211);

      e0 = err_cnt;
      pulse_err(1'b0, 8'h00); idle(2);
      check("idle_rxerr", 64'(err_cnt - e0), 64'd1);

      // Byte arriving during a reply is dropped with frame_err.
      e0 = err_cnt; q0 = txq.size();
      send_byte(8'h83); idle(6); send_byte(8'h55);
      wait_tx(q0 + 4);
      check("txdrop_nbytes", 64'(txq.size() - q0), 64'd4);
      check("txdrop_err",    64'(err_cnt - e0), 64'd1);
      check("txdrop_data",   64'({txq[q0+3], txq[q0+2], txq[q0+1], txq[q0]}), 64'h12345678);

      // Reset mid-transmit, then mid-write.
      send_byte(8'h83); idle(8);
      rst = 1'b1; @(negedge clk);
      check("rst_tx_mid", 64'(tx_transmit), 64'd0);
      rst = 1'b0; idle(2);
      send_byte(8'h07); idle(2); send_byte(8'h01); idle(2);
      rst = 1'b1; idle(2);
      check("rstw_regs",  64'(regs_flat == '0), 64'd1);
      check("rstw_tx",    64'(tx_transmit), 64'd0);
      check("rstw_waddr", 64'(wr_addr), 64'd0);
      rst = 1'b0; idle(2);
      write_frame(7'd7, 32'h13579BDF, 2); idle(3);
      read_frame(7'd7, got, nb);
      check("post_rst_rd_n",    64'(nb), 64'd4);
      check("post_rst_rd_data", 64'(got), 64'h13579BDF);
`else
      // Good write checksum: commit and ACK.
      e0 = err_cnt; w0 = wr_cnt; q0 = txq.size();
      send_byte(8'h02); idle(2); send_byte(8'h01); idle(2); send_byte(8'h02);
      idle(2); send_byte(8'h03); idle(2); send_byte(8'h04); idle(2); send_byte(8'h06);
      wait_tx(q0 + 1);
      check("ck_wr_reg2", 64'(reg_at(2)), 64'h04030201);
      check("ck_wr_strb", 64'(wr_cnt - w0), 64'd1);
      check("ck_wr_err",  64'(err_cnt - e0), 64'd0);
      check("ck_ack_n",   64'(txq.size() - q0), 64'd1);
      check("ck_ack",     64'(txq[q0]), 64'h06);

      // Bad checksum: no write, NAK.
      e0 = err_cnt; w0 = wr_cnt; q0 = txq.size();
      send_byte(8'h02); idle(2); send_byte(8'h0A); idle(2); send_byte(8'h0B);
      idle(2); send_byte(8'h0C); idle(2); send_byte(8'h0D); idle(2); send_byte(8'h07);
      wait_tx(q0 + 1);
      check("ck_bad_reg2", 64'(reg_at(2)), 64'h04030201);
      check("ck_bad_strb", 64'(wr_cnt - w0), 64'd0);
      check("ck_bad_err",  64'(err_cnt - e0), 64'd1);
      check("ck_nak_n",    64'(txq.size() - q0), 64'd1);
      check("ck_nak",      64'(txq[q0]), 64'h15);

      // Read with checksum: data bytes then their XOR.
      e0 = err_cnt; q0 = txq.size();
      send_byte(8'h82); idle(2); send_byte(8'h82);
      wait_tx(q0 + 5);
      check("ck_rd_n",    64'(txq.size() - q0), 64'd5);
      check("ck_rd_data", 64'({txq[q0+3], txq[q0+2], txq[q0+1], txq[q0]}), 64'h04030201);
      check("ck_rd_xor",  64'(txq[q0+4]), 64'h04);
      check("ck_rd_err",  64'(err_cnt - e0), 64'd0);
      check("ck_tx_hold", 64'(viol), 64'd0);
`endif

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
